bus_trace_capture: RTL and testbench

BUS_TRACE_CAPTURE -- requirements
Module: bus_trace_capture

---
 rtl/bus_trace_capture_if.sv | 44 ++++
 rtl/bus_trace_capture.sv | 178 +++++++++++++++++
 tb/tb_bus_trace_capture.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/bus_trace_capture_if.sv
// Signal bundle between a bus trace capture unit and its controller.
//   A_BUS/D_BUS/RW/SYNC : monitored CPU bus
//   arm/stop/mode       : capture control
//   trig_addr/post_cnt  : trigger address and post-trigger entry count
//   rd_req              : pop oldest trace entry
//   busy/done/triggered/overflow/count : capture status
//   rd_valid/rd_entry   : popped entry {cycle, A_BUS, D_BUS, RW, SYNC}
interface bus_trace_capture_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int CYC_W  = 16
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int ENT_W = CYC_W + ADDR_W + DATA_W + 2;

    logic [ADDR_W-1:0] A_BUS;
    logic [DATA_W-1:0] D_BUS;
    logic              RW;
    logic              SYNC;
    logic              arm;
    logic              stop;
    logic [1:0]        mode;
    logic [ADDR_W-1:0] trig_addr;
    logic [PTR_W-1:0]  post_cnt;
    logic              rd_req;
    logic              busy;
    logic              done;
    logic              triggered;
    logic              overflow;
    logic [PTR_W:0]    count;
    logic              rd_valid;
    logic [ENT_W-1:0]  rd_entry;

    modport slave (
        input  A_BUS, D_BUS, RW, SYNC, arm, stop, mode, trig_addr, post_cnt, rd_req,
        output busy, done, triggered, overflow, count, rd_valid, rd_entry
    );

    modport master (
        output A_BUS, D_BUS, RW, SYNC, arm, stop, mode, trig_addr, post_cnt, rd_req,
        input  busy, done, triggered, overflow, count, rd_valid, rd_entry
    );
endinterface

// File: rtl/bus_trace_capture.sv
// Bus trace capture: records {cycle, A_BUS, D_BUS, RW, SYNC} snapshots of a
// monitored CPU bus into a circular buffer, with free-run, start-on-trigger,
// stop-after-trigger and opcode-only capture modes. Entries are popped
// oldest-first once capture is done.
//   clk : capture clock, rising edge
//   RST : asynchronous active-high reset
//   bus : bus_trace_capture_if slave (monitored bus, control, status, readout)
//
// state     | meaning
// ----------+---------------------------------------------------------
// S_IDLE    | after reset, nothing captured, waiting for arm
// S_WAIT_TRIG| armed in mode 01, waiting for trigger address
// S_CAPTURE | writing entries according to latched mode
// S_POST    | mode 10, writing remaining post-trigger entries
// S_DONE    | capture finished, entries available for readout
module bus_trace_capture #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int CYC_W  = 16
) (
    input  logic                clk,
    input  logic                RST,
    bus_trace_capture_if.slave  bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int ENT_W = CYC_W + ADDR_W + DATA_W + 2;
    localparam logic [PTR_W:0] CNT_FULL    = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0] CNT_FULL_M1 = (PTR_W+1)'(DEPTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_TRIG,
        S_CAPTURE,
        S_POST,
        S_DONE
    } state_t;

    state_t             state, state_nxt;
    logic [CYC_W-1:0]   cyc;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W:0]     count;
    logic               overflow;
    logic               triggered;
    logic [1:0]         mode_q;
    logic [PTR_W-1:0]   post_q;
    logic [PTR_W-1:0]   remaining;
    logic               rd_valid;
    logic [ENT_W-1:0]   rd_entry;
    logic [ENT_W-1:0]   mem [DEPTH];

    logic               trig_hit;
    logic               do_write;
    logic               set_trig;
    logic               load_rem;
    logic               dec_rem;
    logic               do_pop;
    logic [PTR_W-1:0]   rd_idx;

    assign trig_hit = (state == S_WAIT_TRIG || state == S_CAPTURE || state == S_POST)
                      && !triggered && (bus.A_BUS == bus.trig_addr);

    // Oldest entry; when full, count[PTR_W-1:0] is 0 and this lands on wr_ptr.
    assign rd_idx = wr_ptr - count[PTR_W-1:0];

    always_comb begin
        state_nxt = state;
        do_write  = 1'b0;
        set_trig  = 1'b0;
        load_rem  = 1'b0;
        dec_rem   = 1'b0;
        do_pop    = 1'b0;
        if (bus.arm) begin
            state_nxt = (bus.mode == 2'b01) ? S_WAIT_TRIG : S_CAPTURE;
        end else begin
            case (state)
                S_WAIT_TRIG: begin
                    if (bus.stop) begin
                        state_nxt = S_DONE;
                    end else if (trig_hit) begin
                        do_write  = 1'b1;
                        set_trig  = 1'b1;
                        state_nxt = S_CAPTURE;
                    end
                end
                S_CAPTURE: begin
                    if (bus.stop) begin
                        state_nxt = S_DONE;
                    end else begin
                        set_trig = trig_hit;
                        case (mode_q)
                            2'b00: do_write = 1'b1;
                            2'b01: begin
                                do_write = 1'b1;
                                if (count == CNT_FULL_M1) state_nxt = S_DONE;
                            end
                            2'b10: begin
                                do_write = 1'b1;
                                if (trig_hit) begin
                                    load_rem  = 1'b1;
                                    state_nxt = (post_q == '0) ? S_DONE : S_POST;
                                end
                            end
                            default: begin
                                do_write = bus.SYNC;
                                if (bus.SYNC && count == CNT_FULL_M1) state_nxt = S_DONE;
                            end
                        endcase
                    end
                end
                S_POST: begin
                    if (bus.stop) begin
                        state_nxt = S_DONE;
                    end else begin
                        do_write = 1'b1;
                        dec_rem  = 1'b1;
                        if (remaining == PTR_W'(1)) state_nxt = S_DONE;
                    end
                end
                S_DONE: do_pop = bus.rd_req && (count != '0);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            state     <= S_IDLE;
            cyc       <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            triggered <= 1'b0;
            mode_q    <= 2'b00;
            post_q    <= '0;
            remaining <= '0;
            rd_valid  <= 1'b0;
            rd_entry  <= '0;
        end else begin
            state    <= state_nxt;
            cyc      <= cyc + 1'b1;
            rd_valid <= do_pop;
            if (do_pop) rd_entry <= mem[rd_idx];
            if (bus.arm) begin
                wr_ptr    <= '0;
                count     <= '0;
                overflow  <= 1'b0;
                triggered <= 1'b0;
                mode_q    <= bus.mode;
                post_q    <= bus.post_cnt;
                remaining <= '0;
            end else begin
                if (set_trig) triggered <= 1'b1;
                if (do_write) begin
                    wr_ptr <= wr_ptr + 1'b1;
                    if (count == CNT_FULL) overflow <= 1'b1;
                    else                   count    <= count + 1'b1;
                end
                if (do_pop) count <= count - 1'b1;
                if (load_rem)     remaining <= post_q;
                else if (dec_rem) remaining <= remaining - 1'b1;
            end
        end
    end

    // Trace storage needs no reset: count governs which entries are valid.
    always_ff @(posedge clk) begin
        if (do_write) mem[wr_ptr] <= {cyc, bus.A_BUS, bus.D_BUS, bus.RW, bus.SYNC};
    end

    assign bus.busy      = (state == S_WAIT_TRIG) || (state == S_CAPTURE) || (state == S_POST);
    assign bus.done      = (state == S_DONE);
    assign bus.triggered = triggered;
    assign bus.overflow  = overflow;
    assign bus.count     = count;
    assign bus.rd_valid  = rd_valid;
    assign bus.rd_entry  = rd_entry;
endmodule

// File: tb/tb_bus_trace_capture.sv
// Directed testbench for bus_trace_capture with default parameters.
module tb_bus_trace_capture;
    localparam int ENT_W = 42;

    logic clk = 1'b0;
    logic RST = 1'b0;
    always #5 clk = ~clk;

    bus_trace_capture_if bif ();

    bus_trace_capture dut (
        .clk (clk),
        .RST (RST),
        .bus (bif.slave)
    );

    int n_checks = 0;
    int n_errors = 0;
    int tb_cyc   = 0;
    logic [ENT_W-1:0] exp_q [$];
    logic [ENT_W-1:0] e;
    logic [ENT_W-1:0] last_entry = '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        tb_cyc++;
    endtask

    function automatic logic [ENT_W-1:0] mk(input int c, input logic [15:0] a, input logic s);
        logic [15:0] c16;
        c16 = c[15:0];
        return {c16, a, a[7:0] ^ 8'h5A, a[0], s};
    endfunction

    task automatic put(input logic [15:0] a, input logic s);
        bif.A_BUS = a;
        bif.D_BUS = a[7:0] ^ 8'h5A;
        bif.RW    = a[0];
        bif.SYNC  = s;
        e = mk(tb_cyc, a, s);
    endtask

    task automatic arm_mode(input logic [1:0] m, input logic [15:0] t, input logic [3:0] pc);
        bif.mode      = m;
        bif.trig_addr = t;
        bif.post_cnt  = pc;
        bif.arm       = 1'b1;
        tick();
        bif.arm       = 1'b0;
    endtask

    task automatic pop_check(input int n, input string tag);
        bif.rd_req = 1'b1;
        for (int i = 0; i < n; i++) begin
            tick();
            last_entry = exp_q.pop_front();
            check({tag, "_valid"}, 64'(bif.rd_valid), 64'd1);
            check({tag, "_entry"}, 64'(bif.rd_entry), 64'(last_entry));
        end
        bif.rd_req = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},      64'(bif.busy),      64'd0);
        check({tag, "_done"},      64'(bif.done),      64'd0);
        check({tag, "_triggered"}, 64'(bif.triggered), 64'd0);
        check({tag, "_overflow"},  64'(bif.overflow),  64'd0);
        check({tag, "_rd_valid"},  64'(bif.rd_valid),  64'd0);
        check({tag, "_count"},     64'(bif.count),     64'd0);
        check({tag, "_rd_entry"},  64'(bif.rd_entry),  64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bif.A_BUS = '0; bif.D_BUS = '0; bif.RW = 1'b0; bif.SYNC = 1'b0;
        bif.arm = 1'b0; bif.stop = 1'b0; bif.mode = 2'b00;
        bif.trig_addr = '0; bif.post_cnt = '0; bif.rd_req = 1'b0;

        // Reset
        #2 RST = 1'b1;
        #1;
        check_all_zero("reset");
        tick(); tick();
        RST = 1'b0;
        tb_cyc = 0;

        // Mode 01: start on trigger at 0x8005
        arm_mode(2'b01, 16'h8005, 4'd0);
        check("t1_busy_wait", 64'(bif.busy), 64'd1);
        for (int i = 0; i < 5; i++) begin
            put(16'(16'h8000 + i), 1'b0);
            tick();
        end
        check("t1_no_write_before_trig", 64'(bif.count), 64'd0);
        check("t1_not_triggered", 64'(bif.triggered), 64'd0);
        for (int i = 0; i < 16; i++) begin
            put(16'(16'h8005 + i), 1'b0);
            exp_q.push_back(e);
            tick();
            if (i == 14) check("t1_not_done_15", 64'(bif.done), 64'd0);
        end
        check("t1_done", 64'(bif.done), 64'd1);
        check("t1_count", 64'(bif.count), 64'd16);
        check("t1_triggered", 64'(bif.triggered), 64'd1);
        check("t1_overflow", 64'(bif.overflow), 64'd0);
        pop_check(16, "t1_pop");
        check("t1_last_addr", 64'(bif.rd_entry[25:10]), 64'h8014);
        check("t1_count_empty", 64'(bif.count), 64'd0);
        tick();
        check("t1_rd_valid_low", 64'(bif.rd_valid), 64'd0);

        // rd_req with count 0 in DONE
        bif.rd_req = 1'b1;
        tick();
        bif.rd_req = 1'b0;
        check("t1_empty_rd_valid", 64'(bif.rd_valid), 64'd0);
        check("t1_empty_rd_entry", 64'(bif.rd_entry), 64'(last_entry));

        // Mode 00: free run 20 cycles then stop
        arm_mode(2'b00, 16'hFFFF, 4'd0);
        for (int i = 0; i < 20; i++) begin
            put(16'(16'h2000 + i), 1'b0);
            exp_q.push_back(e);
            if (i == 3) bif.rd_req = 1'b1;
            tick();
            if (i == 5) begin
                check("t2_capture_rd_valid", 64'(bif.rd_valid), 64'd0);
                check("t2_capture_rd_entry", 64'(bif.rd_entry), 64'(last_entry));
            end
        end
        bif.rd_req = 1'b0;
        put(16'h20FF, 1'b0);
        bif.stop = 1'b1;
        tick();
        bif.stop = 1'b0;
        check("t2_done", 64'(bif.done), 64'd1);
        check("t2_count", 64'(bif.count), 64'd16);
        check("t2_overflow", 64'(bif.overflow), 64'd1);
        check("t2_triggered", 64'(bif.triggered), 64'd0);
        repeat (4) void'(exp_q.pop_front());
        pop_check(16, "t2_pop");
        check("t2_count_empty", 64'(bif.count), 64'd0);
        tick();

        // Mode 10: trigger at 0x1234 after 10 cycles, post_cnt 3
        arm_mode(2'b10, 16'h1234, 4'd3);
        for (int i = 0; i < 10; i++) begin
            put(16'(16'h1000 + i), 1'b0);
            exp_q.push_back(e);
            tick();
        end
        put(16'h1234, 1'b0);
        exp_q.push_back(e);
        tick();
        check("t3_post_busy", 64'(bif.busy), 64'd1);
        check("t3_triggered_now", 64'(bif.triggered), 64'd1);
        for (int j = 0; j < 3; j++) begin
            put(16'(16'h1300 + j), 1'b0);
            exp_q.push_back(e);
            tick();
            if (j == 1) check("t3_not_done_yet", 64'(bif.done), 64'd0);
        end
        check("t3_done", 64'(bif.done), 64'd1);
        check("t3_count", 64'(bif.count), 64'd14);
        check("t3_overflow", 64'(bif.overflow), 64'd0);
        put(16'h1400, 1'b0);
        tick();
        check("t3_no_write_in_done", 64'(bif.count), 64'd14);
        pop_check(14, "t3_pop");
        check("t3_last_addr", 64'(bif.rd_entry[25:10]), 64'h1302);
        tick();

        // Mode 11: SYNC every third cycle
        arm_mode(2'b11, 16'hFFFF, 4'd0);
        for (int i = 0; i < 48; i++) begin
            put(16'(16'h3000 + i), (i % 3) == 2);
            if ((i % 3) == 2) exp_q.push_back(e);
            tick();
            if (i == 46) check("t4_not_done_47", 64'(bif.done), 64'd0);
        end
        check("t4_done", 64'(bif.done), 64'd1);
        check("t4_count", 64'(bif.count), 64'd16);
        pop_check(16, "t4_pop");
        check("t4_sync_bit", 64'(bif.rd_entry[0]), 64'd1);
        tick();

        // Reset mid-POST, arm ignored during reset, then fresh mode 01 capture
        arm_mode(2'b10, 16'h4444, 4'd5);
        put(16'h4000, 1'b0); tick();
        put(16'h4444, 1'b0); tick();
        put(16'h4001, 1'b0); tick();
        check("t5_in_post", 64'(bif.busy), 64'd1);
        RST = 1'b1;
        bif.arm = 1'b1;
        #1;
        check_all_zero("t5_rst");
        tick(); tick();
        check("t5_arm_ignored_busy", 64'(bif.busy), 64'd0);
        check("t5_arm_ignored_count", 64'(bif.count), 64'd0);
        RST = 1'b0;
        bif.arm = 1'b0;
        tb_cyc = 0;
        exp_q.delete();
        arm_mode(2'b01, 16'h5000, 4'd0);
        check("t5_fresh_count", 64'(bif.count), 64'd0);
        check("t5_fresh_busy", 64'(bif.busy), 64'd1);
        for (int i = 0; i < 16; i++) begin
            put(16'(16'h5000 + i), 1'b1);
            exp_q.push_back(e);
            tick();
            if (i == 0) check("t5_first_write", 64'(bif.count), 64'd1);
        end
        check("t5_done", 64'(bif.done), 64'd1);
        pop_check(1, "t5_pop");
        check("t5_first_cycle", 64'(bif.rd_entry[41:26]), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
